// File: rtl/warbler_pkg.sv
// warbler_pkg: shared types and default sizing for the warbler packer.
//   state_e        - collector FSM states (idle, warm-up discard, collect)
//   DEF_*          - default parameter values for the packer and its interface
package warbler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2
  } state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_WARMUP     = 64;

endpackage

// File: rtl/warbler_packer_if.sv
// warbler_packer_if: bundles the bit-stream input, the word output handshake
// and the status flags of the warbler packer.
//   start, bit_in, bit_ce       - producer side (controller / NLFSR stage)
//   out_data, out_valid,
//   out_ready                   - consumer valid/ready word stream
//   stall, busy, overflow       - status back to the stage controller
// Modports: master drives the bit stream and out_ready; slave is the packer.
interface warbler_packer_if #(
  parameter int WORD_W = warbler_pkg::DEF_WORD_W
);
  logic              start;
  logic              bit_in;
  logic              bit_ce;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              stall;
  logic              busy;
  logic              overflow;

  modport master (
    output start, bit_in, bit_ce, out_ready,
    input  out_data, out_valid, stall, busy, overflow
  );

  modport slave (
    input  start, bit_in, bit_ce, out_ready,
    output out_data, out_valid, stall, busy, overflow
  );
endinterface

// File: rtl/trng_fifo.sv
// trng_fifo: synchronous word FIFO for packed random words.
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - synchronous clear of pointers and count (wins over push/pop)
//   push       - write push_data; accepted when not full or popping this cycle
//   pop        - remove head word; ignored when empty
//   pop_data   - head word, zero while empty
//   full/empty - occupancy flags, count - registered occupancy (0..DEPTH)
module trng_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  // Masking the head keeps out_data at zero after reset without resetting mem.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // count, so a reset here would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/warbler_packer.sv
// warbler_packer: collects the single-bit warbler output of the NLFSR stage,
// drops WARMUP bits after each start, packs the rest MSB-first into WORD_W
// words and buffers them in a FIFO_DEPTH-word FIFO.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - warbler_packer_if.slave: start/bit_in/bit_ce in, word stream
//              out_data/out_valid/out_ready, status stall/busy/overflow
module warbler_packer
  import warbler_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WARMUP     = DEF_WARMUP
) (
  input  logic            clk,
  input  logic            rst,
  warbler_packer_if.slave bus
);
  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  state_e             state_q, state_d;
  logic [WARM_W-1:0]  warm_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  shift_q;
  logic [WORD_W-1:0]  word_next;
  logic               warm_take, bit_take, word_done, pop;
  logic               overflow_q;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    warm_take = 1'b0;
    bit_take  = 1'b0;
    if (bus.start) begin
      // bit_ce on the start cycle is ignored; collection begins next edge.
      state_d = (WARMUP > 0) ? ST_WARMUP : ST_COLLECT;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          if (bus.bit_ce) begin
            warm_take = 1'b1;
            if (warm_cnt == WARM_LAST) state_d = ST_COLLECT;
          end
        end
        ST_COLLECT: bit_take = bus.bit_ce;
        default:    ;
      endcase
    end
  end

  assign word_next = {shift_q[WORD_W-2:0], bus.bit_in};
  assign word_done = bit_take && (bit_cnt == BIT_LAST);
  assign pop       = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.start) begin
      warm_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (warm_take) warm_cnt <= warm_cnt + 1'b1;
      if (bit_take) begin
        shift_q <= word_next;
        // Wrap even when the word is dropped so later words stay aligned.
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  trng_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.start),
    .push      (word_done),
    .push_data (word_next),
    .pop       (bus.out_ready),
    .pop_data  (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.stall     = (fifo_count == CNT_FULL);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_warbler_packer.sv
// Bench for warbler_packer: instance A (WORD_W=8, DEPTH=4, WARMUP=4) and
// instance B (same, WARMUP=0). A queue-level model predicts every output on
// every cycle; literal checks pin the model on the documented scenarios.
module tb_warbler_packer;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_v [2];
  logic         bit_v   [2];
  logic         ce_v    [2];
  logic         rdy_v   [2];
  logic [W-1:0] o_data  [2];
  logic         o_valid [2];
  logic         o_stall [2];
  logic         o_busy  [2];
  logic         o_ovf   [2];

  warbler_packer_if #(.WORD_W(W)) bus_a ();
  warbler_packer_if #(.WORD_W(W)) bus_b ();

  assign bus_a.start     = start_v[0];
  assign bus_a.bit_in    = bit_v[0];
  assign bus_a.bit_ce    = ce_v[0];
  assign bus_a.out_ready = rdy_v[0];
  assign bus_b.start     = start_v[1];
  assign bus_b.bit_in    = bit_v[1];
  assign bus_b.bit_ce    = ce_v[1];
  assign bus_b.out_ready = rdy_v[1];

  assign o_data[0]  = bus_a.out_data;
  assign o_valid[0] = bus_a.out_valid;
  assign o_stall[0] = bus_a.stall;
  assign o_busy[0]  = bus_a.busy;
  assign o_ovf[0]   = bus_a.overflow;
  assign o_data[1]  = bus_b.out_data;
  assign o_valid[1] = bus_b.out_valid;
  assign o_stall[1] = bus_b.stall;
  assign o_busy[1]  = bus_b.busy;
  assign o_ovf[1]   = bus_b.overflow;

  warbler_packer #(.WORD_W(W), .FIFO_DEPTH(D), .WARMUP(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  warbler_packer #(.WORD_W(W), .FIFO_DEPTH(D), .WARMUP(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_run  [2];
  int m_warm [2];
  int m_bits [2];
  int m_cur  [2];
  int m_cnt  [2];
  int m_ovf  [2];
  int m_q    [2][D];

  function automatic int warmup_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_warm[i] = 0; m_bits[i] = 0;
        m_cur[i] = 0; m_cnt[i]  = 0; m_ovf[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit do_pop;
        bit do_push;
        int word;
        do_pop  = (m_cnt[i] > 0) && (rdy_v[i] == 1'b1);
        do_push = 1'b0;
        word    = 0;
        if (start_v[i]) begin
          m_run[i] = 1; m_warm[i] = 0; m_bits[i] = 0;
          m_cur[i] = 0; m_cnt[i]  = 0; m_ovf[i]  = 0;
        end else begin
          if (m_run[i] != 0 && ce_v[i] == 1'b1) begin
            if (m_warm[i] < warmup_of(i)) begin
              m_warm[i]++;
            end else begin
              m_cur[i] = ((m_cur[i] << 1) | int'(bit_v[i])) & ((1 << W) - 1);
              m_bits[i]++;
              if (m_bits[i] == W) begin
                do_push   = 1'b1;
                word      = m_cur[i];
                m_bits[i] = 0;
              end
            end
          end
          if (do_pop) begin
            for (int k = 0; k < D - 1; k++) m_q[i][k] = m_q[i][k+1];
            m_cnt[i]--;
          end
          if (do_push) begin
            if (m_cnt[i] < D) begin
              m_q[i][m_cnt[i]] = word;
              m_cnt[i]++;
            end else begin
              m_ovf[i] = 1;
            end
          end
        end
      end
    end
  end

  // Compare process: outputs are registered, so the falling edge is quiet.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid[%0d]", i), int'(o_valid[i]), int'(m_cnt[i] > 0));
      check($sformatf("stall[%0d]", i), int'(o_stall[i]), int'(m_cnt[i] == D));
      check($sformatf("busy[%0d]", i),  int'(o_busy[i]),  m_run[i]);
      check($sformatf("ovf[%0d]", i),   int'(o_ovf[i]),   m_ovf[i]);
      if (m_cnt[i] > 0) check($sformatf("data[%0d]", i), int'(o_data[i]), m_q[i][0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int i, input logic s, input logic ce, input logic b, input logic r);
    for (int j = 0; j < 2; j++) begin
      start_v[j] = 1'b0; ce_v[j] = 1'b0; bit_v[j] = 1'b0; rdy_v[j] = 1'b0;
    end
    start_v[i] = s; ce_v[i] = ce; bit_v[i] = b; rdy_v[i] = r;
    @(negedge clk);
  endtask

  task automatic send_word(input int i, input logic [W-1:0] w, input logic r_last);
    for (int k = W - 1; k >= 0; k--) cyc(i, 1'b0, 1'b1, w[k], (k == 0) ? r_last : 1'b0);
  endtask

  task automatic warm_a();
    for (int k = 0; k < 4; k++) cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [11:0] pat;
    logic [7:0]  gap;
    for (int j = 0; j < 2; j++) begin
      start_v[j] = 1'b0; ce_v[j] = 1'b0; bit_v[j] = 1'b0; rdy_v[j] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_data",  int'(o_data[0]),  0);
    check("rst_valid", int'(o_valid[0]), 0);
    check("rst_busy",  int'(o_busy[0]),  0);
    check("rst_stall", int'(o_stall[0]), 0);
    check("rst_ovf",   int'(o_ovf[0]),   0);
    rst = 1'b0;

    // Warm-up drop: first four bits discarded, then 1010_0101 -> 0xA5.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_busy", int'(o_busy[0]), 1);
    pat = 12'b1111_1010_0101;
    for (int k = 11; k >= 0; k--) begin
      cyc(0, 1'b0, 1'b1, pat[k], 1'b0);
      if (k == 1) check("t1_valid_early", int'(o_valid[0]), 0);
    end
    check("t1_valid", int'(o_valid[0]), 1);
    check("t1_data",  int'(o_data[0]),  32'hA5);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_popped", int'(o_valid[0]), 0);

    // Gapped enable on the no-warm-up instance; noise on idle cycles.
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0);
    gap = 8'hC3;
    for (int k = 7; k >= 0; k--) begin
      cyc(1, 1'b0, 1'b1, gap[k], 1'b0);
      if (k != 0) cyc(1, 1'b0, 1'b0, ~gap[k], 1'b0);
    end
    check("t2_valid", int'(o_valid[1]), 1);
    check("t2_data",  int'(o_data[1]),  32'hC3);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: five words into a four-deep FIFO, fifth is lost.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    warm_a();
    for (int n = 1; n <= 5; n++) begin
      send_word(0, 8'(n), 1'b0);
      if (n == 4) begin
        check("t3_stall4", int'(o_stall[0]), 1);
        check("t3_ovf4",   int'(o_ovf[0]),   0);
      end
    end
    check("t3_ovf",   int'(o_ovf[0]),   1);
    check("t3_stall", int'(o_stall[0]), 1);
    for (int n = 1; n <= 4; n++) begin
      check("t3_drain", int'(o_data[0]), n);
      cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("t3_empty",  int'(o_valid[0]), 0);
    check("t3_sticky", int'(o_ovf[0]),   1);

    // Restart mid-word: FIFO and overflow flushed, warm-up applied again.
    send_word(0, 8'h77, 1'b0);
    for (int k = 0; k < 3; k++) cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_valid", int'(o_valid[0]), 0);
    check("t5_ovf",   int'(o_ovf[0]),   0);
    check("t5_stall", int'(o_stall[0]), 0);
    check("t5_busy",  int'(o_busy[0]),  1);
    warm_a();
    send_word(0, 8'h5A, 1'b0);
    check("t5_data", int'(o_data[0]), 32'h5A);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full FIFO with a pop on the completing edge: no loss, stays full.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    warm_a();
    send_word(0, 8'h11, 1'b0);
    send_word(0, 8'h22, 1'b0);
    send_word(0, 8'h33, 1'b0);
    send_word(0, 8'h44, 1'b0);
    check("t4_full", int'(o_stall[0]), 1);
    send_word(0, 8'h55, 1'b1);
    check("t4_ovf",   int'(o_ovf[0]),   0);
    check("t4_stall", int'(o_stall[0]), 1);
    check("t4_head",  int'(o_data[0]),  32'h22);

    // Asynchronous reset while words are pending.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", int'(o_valid[0]), 0);
    check("t6_busy",  int'(o_busy[0]),  0);
    check("t6_stall", int'(o_stall[0]), 0);
    check("t6_ovf",   int'(o_ovf[0]),   0);
    check("t6_data",  int'(o_data[0]),  0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) cyc(0, 1'b0, 1'b1, 1'(k & 1), 1'b0);
    check("t6_idle_busy",  int'(o_busy[0]),  0);
    check("t6_idle_valid", int'(o_valid[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/warbler_packer.md
# warbler_packer

Serial-to-parallel collector directly downstream of the third NLFSR stage. Samples the single-bit warbler output on every cycle that the NLFSR clock-enable is asserted, and discards a programmable warm-up prefix after each start. It packs the remaining bits MSB-first into words and buffers them in a small FIFO. The words are presented to the consumer over a valid/ready interface, and back-pressure is signalled to the stage controller.

## Interface
- WORD_W, 32, output word width in bits (≥2)
- FIFO_DEPTH, 4, number of buffered words (power of two, ≥2)
- WARMUP, 64, bits discarded after each start (0 allowed)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; (re)starts collection, flushes everything
- bit_in  in  1  warbler output of the NLFSR stage
- bit_ce  in  1  same enable that clocks the NLFSR; bit_in valid this cycle
- out_data  out  WORD_W  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head word
- stall  out  1  FIFO full; controller should drop bit_ce
- busy  out  1  state ≠ IDLE
- overflow  out  1  sticky; a completed word was lost

## Operation
- States: IDLE, WARMUP, COLLECT. Reset → IDLE.
- start (any state) → WARMUP if WARMUP>0, else COLLECT. It clears the warm-up counter, bit counter, shift register, FIFO and overflow on the same edge. bit_ce on the start cycle is ignored.
- IDLE: bit_ce ignored.
- WARMUP: each bit_ce increments the warm-up counter. The transition to COLLECT happens on the edge of the WARMUP-th sampled bit. Warm-up bits never enter the shift register.
- COLLECT: each bit_ce shifts bit_in into the LSB of the shift register and increments the bit counter, so the first collected bit ends up in out_data[WORD_W-1].
- On the edge where the WORD_W-th bit is sampled, the completed word, including that bit, is pushed to the FIFO and the bit counter wraps to 0. Collection continues indefinitely until the next start or reset.
- If a word completes while the FIFO is full and no pop occurs that cycle:
  - the word is discarded and overflow is set;
  - the bit counter still wraps, so subsequent words stay aligned.
- Pop occurs when out_valid && out_ready.
- Simultaneous push and pop when full: both occur and the FIFO stays full without overflow.
- Simultaneous push and pop when empty: the word is written. out_valid rises on the next cycle.
- stall = (FIFO count == FIFO_DEPTH), derived from the registered count. bit_ce is still honoured while stall is high; stall is advisory only.
- Counters: the warm-up counter is $clog2(WARMUP+1) bits and the bit counter is $clog2(WORD_W) bits. The FIFO count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - out_data = 0
  - out_valid = 0
  - stall = 0
  - busy = 0
  - overflow = 0
  - FIFO empty, state IDLE
- Latency from the edge sampling the last bit of a word to out_valid high: 1 cycle (visible immediately after that edge).
- out_data is stable while out_valid && !out_ready. The next head appears the cycle after a pop.
- busy rises the cycle after start. overflow rises the cycle after the losing edge and holds until start or rst.
- Reset asserted mid-word or mid-warm-up returns all state to reset values immediately (asynchronously); partial words are lost.

## Structure
- Package warbler_pkg: state enum (IDLE, WARMUP, COLLECT) and default parameter constants.
- Sub-module trng_fifo: synchronous FIFO with width/depth parameters, push/pop, full/empty, count, and a synchronous flush input driven by start.
- Top level: FSM, warm-up counter, shift register and bit counter, overflow flag.

## Test plan
- Warm-up drop: WORD_W=8, WARMUP=4; start, then bit_ce every cycle with bit_in pattern 1111_1010_0101 → exactly one word 0xA5 appears, with out_valid 1 cycle after the 12th sampled bit.
- Gapped enable: WARMUP=0, bit_ce on alternate cycles, bits 0xC3 MSB-first → out_data=0xC3. Bits on cycles with bit_ce=0 have no effect.
- Back-pressure: out_ready=0, WORD_W=8, DEPTH=4; stream 5 words 0x01..0x05 → stall high after the 4th push, 5th word lost, overflow=1. Draining yields 0x01..0x04 in order.
- Full push/pop: FIFO full and out_ready=1 on the edge a word completes → pop and push both occur, overflow stays 0, count stays 4.
- Restart mid-word: after 3 collected bits, pulse start → FIFO empty, overflow cleared, WARMUP bits discarded again, and the next word is built only from post-warm-up bits.
- Async reset during COLLECT with out_valid=1 → all outputs 0 and busy=0 immediately. bit_ce afterwards is ignored until start.
